noc_credit_channel_fifo: RTL and testbench
==========================================

Name: noc_credit_channel_fifo

Overview:
- Point-to-point channel buffer between one router's egress port and the next router's ingress port, e.g. router A east to router B west.
- Accepts flits from upstream with valid/ready and holds up to DEPTH flits.
- Forwards flits downstream only when it holds a downstream credit.
- Returns one credit pulse upstream per flit it releases, so the upstream router's credit_in_* counts real buffer frees.

Parameters:
- FLIT_WIDTH, 64, flit width in bits.
- DEPTH, 4, FIFO entries; must be a power of two, at least 2.
- CREDIT_INIT, 2, downstream credits loaded at reset.
- CREDIT_W, 4, credit counter width; CREDIT_INIT must not exceed 2^CREDIT_W-1.

Ports:
- clk  in  1  system clock, all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- flit_in  in  FLIT_WIDTH  upstream flit.
- valid_in  in  1  upstream flit valid.
- ready_out  out  1  FIFO can accept a flit; equals !full.
- credit_out  out  1  one-cycle credit pulse to upstream credit_in.
- flit_out  out  FLIT_WIDTH  head-of-FIFO flit.
- valid_out  out  1  high when the FIFO is not empty and credit_cnt>0.
- ready_in  in  1  downstream ingress ready.
- credit_in  in  1  one-cycle credit return from downstream.
- occupancy  out  clog2(DEPTH+1)  current entry count.
- credit_level  out  CREDIT_W  current downstream credit count.
- credit_overflow  out  1  sticky flag: a credit arrived while the counter was saturated.

Behaviour:
- Reset (synchronous, active-high) clears pointers, occupancy and credit_out, and clears credit_overflow.
- At reset, credit_cnt=CREDIT_INIT; ready_out=1, valid_out=0, flit_out=0.
- Reset asserted mid-transfer discards all buffered flits. No credit pulses are emitted for the discarded flits.
- push = valid_in & ready_out. It writes flit_in at wr_ptr, and wr_ptr wraps modulo DEPTH.
- pop = valid_out & ready_in. It advances rd_ptr modulo DEPTH.
- flit_out is driven combinationally from mem[rd_ptr] (first-word fall-through).
- Zero-cycle bypass is not allowed: a flit pushed in cycle N is visible on valid_out no earlier than cycle N+1.
- Occupancy next value = occupancy + push - pop. Push and pop in the same cycle leave occupancy unchanged.
- When full, ready_out=0 and valid_in is ignored. Push and pop in the same cycle when full are not possible, because ready_out is already low.
- When empty, valid_out=0 and flit_out holds the stale mem value; the value is undefined but must not be X after reset.
- Credit counter next value = credit_cnt - pop + credit_in.
  - pop with credit_in in the same cycle leaves the count unchanged.
  - A credit_in arriving with credit_cnt = 2^CREDIT_W-1 and no pop saturates the counter and sets credit_overflow; the flag stays set until reset.
  - credit_cnt=0 forces valid_out=0 (stall), even when the FIFO is non-empty.
- credit_out is registered: credit_out <= pop. It follows the pop by exactly 1 cycle, one pulse per flit with no coalescing.
- Latency with credit available and ready_in=1: flit accepted at edge N, valid_out at N+1, popped at edge N+1, credit_out high during N+1..N+2.
- Conservation: total credit_out pulses equals total pops, and never exceeds total pushes.

Optional Feature:
- Macro: NOC_CHAN_STATS_EN.
- When defined, adds three 32-bit output counters, all cleared on reset and saturating at 2^32-1:
  - stall_full_count: increments each cycle valid_in=1 && ready_out=0.
  - stall_credit_count: increments each cycle the FIFO is non-empty && credit_cnt=0.
  - flits_fwd_count: increments on each pop.
- When undefined, these ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package noc_chan_pkg holds:
  - FLIT_WIDTH default constant.
  - Credit width constant.
  - flit_t typedef.
  - Function clog2_safe for the pointer and occupancy widths.
- One natural sub-module: noc_credit_counter. It owns the up/down saturating counter, the overflow flag and the stall qualification.
- The FIFO storage and pointers remain inline in the top module.

Test Plan:
- Reset defaults: after reset, expect ready_out=1, valid_out=0, occupancy=0, credit_level=2, credit_out=0, credit_overflow=0.
- Streaming, no credit return: push flits 0xD000..0xD003 back-to-back with ready_in=1 and credit_in=0.
  - Expect 0xD000 and 0xD001 to leave in order and credit_level to reach 0.
  - Expect valid_out=0 with occupancy=2, and exactly two credit_out pulses, each one cycle after its pop.
- Fill to full: 6 pushes with credit_in=0.
  - Expect occupancy to reach 4 and ready_out=0.
  - Expect the 5th and 6th flits to be ignored, without corrupting mem.
- Refill after exhaustion: with credit_level=0 and occupancy=4, pulse credit_in for 1 cycle.
  - Expect credit_level=1, then exactly one pop on the next cycle, and credit_level back to 0.
  - Expect one credit_out pulse and occupancy=3.
- Simultaneous events: pop with credit_in high and push in the same cycle.
  - Expect occupancy and credit_level both unchanged, and FIFO order preserved.
- Saturation and reset mid-operation:
  - Drive 20 credit_in pulses from 2 with CREDIT_W=4: expect credit_level=15 and credit_overflow=1.
  - Then assert reset with occupancy=3: expect occupancy=0, credit_level=2, credit_overflow=0, and no credit_out pulse.

Source files
------------

// File: rtl/noc_chan_pkg.sv
// rtl/noc_chan_pkg.sv - shared constants, flit type and width helper for the credit channel FIFO
//
// Contents:
//   FLIT_WIDTH_DEF  default flit width in bits
//   CREDIT_W_DEF    default downstream credit counter width
//   flit_t          flit of the default width
//   clog2_safe()    ceil(log2(n)) clamped to at least 1, for pointer/occupancy widths
package noc_chan_pkg;

  localparam int FLIT_WIDTH_DEF = 64;
  localparam int CREDIT_W_DEF   = 4;

  typedef logic [FLIT_WIDTH_DEF-1:0] flit_t;

  // Never returns 0 so that a 1-entry range still gets a legal 1-bit vector.
  function automatic int clog2_safe(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/noc_credit_counter.sv
// rtl/noc_credit_counter.sv - saturating downstream credit counter with overflow flag and stall qualification
//
// Ports:
//   clk             in   system clock
//   reset           in   synchronous active-high reset
//   pop             in   a flit leaves the FIFO this cycle (consumes one credit)
//   credit_in       in   one-cycle credit return from downstream
//   fifo_nonempty   in   FIFO holds at least one flit
//   fwd_ok          out  head flit may be offered downstream (non-empty and credit held)
//   stall_credit    out  FIFO has data but no credit is held
//   credit_level    out  current credit count
//   credit_overflow out  sticky: a credit arrived while the counter was saturated
module noc_credit_counter
  import noc_chan_pkg::*;
#(
  parameter int CREDIT_INIT = 2,
  parameter int CREDIT_W    = CREDIT_W_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                pop,
  input  logic                credit_in,
  input  logic                fifo_nonempty,
  output logic                fwd_ok,
  output logic                stall_credit,
  output logic [CREDIT_W-1:0] credit_level,
  output logic                credit_overflow
);

  localparam logic [CREDIT_W-1:0] CNT_MAX  = '1;
  localparam logic [CREDIT_W-1:0] CNT_INIT = CREDIT_W'(CREDIT_INIT);
  localparam logic [CREDIT_W-1:0] CNT_ONE  = CREDIT_W'(1);

  logic [CREDIT_W-1:0] cnt;
  logic                has_credit;

  assign has_credit = (cnt != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt             <= CNT_INIT;
      credit_overflow <= 1'b0;
    end else begin
      // pop and credit_in together cancel; otherwise step by one.
      unique case ({pop, credit_in})
        2'b10: begin
          if (has_credit) begin
            cnt <= cnt - CNT_ONE;
          end
        end
        2'b01: begin
          if (cnt == CNT_MAX) begin
            credit_overflow <= 1'b1;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign credit_level = cnt;
  assign fwd_ok       = fifo_nonempty && has_credit;
  assign stall_credit = fifo_nonempty && !has_credit;

endmodule

// File: rtl/noc_credit_channel_fifo.sv
// rtl/noc_credit_channel_fifo.sv - credit-gated FIFO channel between a router egress and the next router ingress
//
// Optional build macro: NOC_CHAN_STATS_EN adds stall/forward statistics counters.
//
// Ports:
//   clk                 in   system clock
//   reset               in   synchronous active-high reset
//   flit_in             in   upstream flit
//   valid_in            in   upstream flit valid
//   ready_out           out  FIFO can accept a flit (not full)
//   credit_out          out  one-cycle credit pulse upstream, one per released flit
//   flit_out            out  head-of-FIFO flit (first-word fall-through)
//   valid_out           out  FIFO non-empty and a downstream credit is held
//   ready_in            in   downstream ingress ready
//   credit_in           in   one-cycle credit return from downstream
//   occupancy           out  current entry count
//   credit_level        out  current downstream credit count
//   credit_overflow     out  sticky credit-counter overflow flag
//   stall_full_count    out  (NOC_CHAN_STATS_EN) cycles with valid_in while full
//   stall_credit_count  out  (NOC_CHAN_STATS_EN) cycles with data but no credit
//   flits_fwd_count     out  (NOC_CHAN_STATS_EN) flits forwarded downstream
module noc_credit_channel_fifo
  import noc_chan_pkg::*;
#(
  parameter int FLIT_WIDTH  = FLIT_WIDTH_DEF,
  parameter int DEPTH       = 4,
  parameter int CREDIT_INIT = 2,
  parameter int CREDIT_W    = CREDIT_W_DEF
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [FLIT_WIDTH-1:0]            flit_in,
  input  logic                             valid_in,
  output logic                             ready_out,
  output logic                             credit_out,
  output logic [FLIT_WIDTH-1:0]            flit_out,
  output logic                             valid_out,
  input  logic                             ready_in,
  input  logic                             credit_in,
  output logic [clog2_safe(DEPTH+1)-1:0]   occupancy,
  output logic [CREDIT_W-1:0]              credit_level,
  output logic                             credit_overflow
`ifdef NOC_CHAN_STATS_EN
  ,
  output logic [31:0]                      stall_full_count,
  output logic [31:0]                      stall_credit_count,
  output logic [31:0]                      flits_fwd_count
`endif
);

  localparam int PTR_W = clog2_safe(DEPTH);
  localparam int OCC_W = clog2_safe(DEPTH + 1);

  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [OCC_W-1:0] OCC_ONE = OCC_W'(1);
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);

  logic [FLIT_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [OCC_W-1:0]      occ;
  logic                  full;
  logic                  empty;
  logic                  push;
  logic                  pop;
  logic                  fwd_ok;
  logic                  stall_credit;

  // Full/empty come from registered occupancy, so a flit written this cycle
  // cannot appear on valid_out until the next cycle (no bypass path).
  assign full      = (occ == OCC_FULL);
  assign empty     = (occ == '0);
  assign ready_out = !full;
  assign valid_out = fwd_ok;
  assign push      = valid_in && ready_out;
  assign pop       = valid_out && ready_in;
  assign flit_out  = mem[rd_ptr];
  assign occupancy = occ;

  noc_credit_counter #(
    .CREDIT_INIT (CREDIT_INIT),
    .CREDIT_W    (CREDIT_W)
  ) u_credit (
    .clk             (clk),
    .reset           (reset),
    .pop             (pop),
    .credit_in       (credit_in),
    .fifo_nonempty   (!empty),
    .fwd_ok          (fwd_ok),
    .stall_credit    (stall_credit),
    .credit_level    (credit_level),
    .credit_overflow (credit_overflow)
  );

  // Storage is cleared on reset so flit_out is a known value while empty.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
    end else if (push) begin
      mem[wr_ptr] <= flit_in;
      wr_ptr      <= wr_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
    end else if (pop) begin
      rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      occ <= '0;
    end else begin
      unique case ({push, pop})
        2'b10:   occ <= occ + OCC_ONE;
        2'b01:   occ <= occ - OCC_ONE;
        default: occ <= occ;
      endcase
    end
  end

  // One upstream credit per released flit, one cycle after the pop.
  always_ff @(posedge clk) begin
    if (reset) begin
      credit_out <= 1'b0;
    end else begin
      credit_out <= pop;
    end
  end

`ifdef NOC_CHAN_STATS_EN
  localparam logic [31:0] STAT_MAX = '1;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_full_count   <= '0;
      stall_credit_count <= '0;
      flits_fwd_count    <= '0;
    end else begin
      if (valid_in && !ready_out && (stall_full_count != STAT_MAX)) begin
        stall_full_count <= stall_full_count + 32'd1;
      end
      if (stall_credit && (stall_credit_count != STAT_MAX)) begin
        stall_credit_count <= stall_credit_count + 32'd1;
      end
      if (pop && (flits_fwd_count != STAT_MAX)) begin
        flits_fwd_count <= flits_fwd_count + 32'd1;
      end
    end
  end
`else
  logic unused_stall_credit;
  assign unused_stall_credit = stall_credit;
`endif

endmodule

// File: tb/tb_noc_credit_channel_fifo.sv
// tb/tb_noc_credit_channel_fifo.sv - scoreboard bench for the credit channel FIFO
module tb_noc_credit_channel_fifo;
  import noc_chan_pkg::*;

  localparam int DEPTH    = 4;
  localparam int CRED_MAX = 15;
  localparam int CRED_RST = 2;

  logic        clk;
  logic        reset;
  flit_t       flit_in;
  logic        valid_in;
  logic        ready_out;
  logic        credit_out;
  flit_t       flit_out;
  logic        valid_out;
  logic        ready_in;
  logic        credit_in;
  logic [2:0]  occupancy;
  logic [3:0]  credit_level;
  logic        credit_overflow;
`ifdef NOC_CHAN_STATS_EN
  logic [31:0] stall_full_count;
  logic [31:0] stall_credit_count;
  logic [31:0] flits_fwd_count;
`endif

  noc_credit_channel_fifo dut (
    .clk             (clk),
    .reset           (reset),
    .flit_in         (flit_in),
    .valid_in        (valid_in),
    .ready_out       (ready_out),
    .credit_out      (credit_out),
    .flit_out        (flit_out),
    .valid_out       (valid_out),
    .ready_in        (ready_in),
    .credit_in       (credit_in),
    .occupancy       (occupancy),
    .credit_level    (credit_level),
    .credit_overflow (credit_overflow)
`ifdef NOC_CHAN_STATS_EN
    ,
    .stall_full_count   (stall_full_count),
    .stall_credit_count (stall_credit_count),
    .flits_fwd_count    (flits_fwd_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    errors = 0;
  int    checks = 0;
  flit_t q[$];
  int    occ_m;
  int    cred_m;
  bit    ovf_m;
  bit    cred_out_m;
  bit    have_reset = 1'b0;
  int    credit_pulses = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: compare DUT against the model at the falling edge,
  // advance the model with this cycle's inputs, then step past the rising edge.
  task automatic tick();
    bit    exp_valid;
    bit    exp_ready;
    bit    push;
    bit    pop;
    flit_t exp_flit;
    @(negedge clk);
    if (have_reset) begin
      exp_ready = (occ_m < DEPTH);
      exp_valid = (occ_m > 0) && (cred_m > 0);
      chk("ready_out", 64'(ready_out), 64'(exp_ready));
      chk("valid_out", 64'(valid_out), 64'(exp_valid));
      chk("occupancy", 64'(occupancy), 64'(occ_m));
      chk("credit_level", 64'(credit_level), 64'(cred_m));
      chk("credit_overflow", 64'(credit_overflow), 64'(ovf_m));
      chk("credit_out", 64'(credit_out), 64'(cred_out_m));
      if (credit_out === 1'b1) credit_pulses++;
      push = valid_in && exp_ready;
      pop  = exp_valid && ready_in;
      if (!reset) begin
        if (pop) begin
          chk("sb_nonempty", 64'(q.size() != 0), 64'd1);
          if (q.size() != 0) begin
            exp_flit = q.pop_front();
            chk("flit_out", flit_out, exp_flit);
          end
        end
        if (push) q.push_back(flit_in);
        occ_m = occ_m + (push ? 1 : 0) - (pop ? 1 : 0);
        if (pop && !credit_in) begin
          cred_m = cred_m - 1;
        end else if (credit_in && !pop) begin
          if (cred_m == CRED_MAX) ovf_m = 1'b1;
          else cred_m = cred_m + 1;
        end
        cred_out_m = pop;
      end
    end
    if (reset) begin
      q.delete();
      occ_m      = 0;
      cred_m     = CRED_RST;
      ovf_m      = 1'b0;
      cred_out_m = 1'b0;
      have_reset = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset     = 1'b1;
    valid_in  = 1'b0;
    flit_in   = '0;
    ready_in  = 1'b0;
    credit_in = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    // Reset defaults
    chk("rst_ready_out", 64'(ready_out), 64'd1);
    chk("rst_valid_out", 64'(valid_out), 64'd0);
    chk("rst_occupancy", 64'(occupancy), 64'd0);
    chk("rst_credit_level", 64'(credit_level), 64'd2);
    chk("rst_credit_out", 64'(credit_out), 64'd0);
    chk("rst_overflow", 64'(credit_overflow), 64'd0);
    chk("rst_flit_out", flit_out, 64'd0);

    // Streaming with no credit return: two flits leave, two stall
    credit_pulses = 0;
    ready_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      valid_in = 1'b1;
      flit_in  = 64'hD000 + 64'(i);
      tick();
    end
    valid_in = 1'b0;
    tick();
    tick();
    chk("stream_credit_level", 64'(credit_level), 64'd0);
    chk("stream_occupancy", 64'(occupancy), 64'd2);
    chk("stream_valid_out", 64'(valid_out), 64'd0);
    chk("stream_pulses", 64'(credit_pulses), 64'd2);

    // Fill to full: 6 pushes, last two must be ignored
    reset = 1'b1;
    tick();
    reset    = 1'b0;
    ready_in = 1'b0;
    for (int i = 0; i < 6; i++) begin
      valid_in = 1'b1;
      flit_in  = 64'hE000 + 64'(i);
      tick();
    end
    valid_in = 1'b0;
    chk("full_occupancy", 64'(occupancy), 64'd4);
    chk("full_ready_out", 64'(ready_out), 64'd0);

    // Spend both credits, then refill to full without credit
    ready_in = 1'b1;
    tick();
    tick();
    for (int i = 6; i < 8; i++) begin
      valid_in = 1'b1;
      flit_in  = 64'hE000 + 64'(i);
      tick();
    end
    valid_in = 1'b0;
    chk("exh_credit_level", 64'(credit_level), 64'd0);
    chk("exh_occupancy", 64'(occupancy), 64'd4);

    // Single credit return releases exactly one flit
    credit_pulses = 0;
    credit_in = 1'b1;
    tick();
    credit_in = 1'b0;
    chk("refill_credit_level", 64'(credit_level), 64'd1);
    tick();
    chk("refill_credit_after_pop", 64'(credit_level), 64'd0);
    chk("refill_occupancy", 64'(occupancy), 64'd3);
    tick();
    tick();
    chk("refill_pulses", 64'(credit_pulses), 64'd1);

    // Simultaneous pop, credit_in and push
    credit_in = 1'b1;
    tick();
    credit_in = 1'b0;
    chk("sim_pre_credit", 64'(credit_level), 64'd1);
    credit_in = 1'b1;
    valid_in  = 1'b1;
    flit_in   = 64'hF000;
    tick();
    valid_in = 1'b0;
    chk("sim_occupancy", 64'(occupancy), 64'd3);
    chk("sim_credit_level", 64'(credit_level), 64'd1);
    for (int i = 0; i < 4; i++) tick();
    credit_in = 1'b0;
    chk("drain_occupancy", 64'(occupancy), 64'd0);
    chk("drain_credit_level", 64'(credit_level), 64'd2);

    // Saturation, then reset with flits buffered
    reset = 1'b1;
    tick();
    reset    = 1'b0;
    ready_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      valid_in = 1'b1;
      flit_in  = 64'hA000 + 64'(i);
      tick();
    end
    valid_in  = 1'b0;
    credit_in = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    credit_in = 1'b0;
    tick();
    chk("sat_credit_level", 64'(credit_level), 64'd15);
    chk("sat_overflow", 64'(credit_overflow), 64'd1);
    chk("sat_occupancy", 64'(occupancy), 64'd3);

    credit_pulses = 0;
    ready_in = 1'b1;
    reset    = 1'b1;
    tick();
    reset    = 1'b0;
    ready_in = 1'b0;
    chk("mrst_occupancy", 64'(occupancy), 64'd0);
    chk("mrst_credit_level", 64'(credit_level), 64'd2);
    chk("mrst_overflow", 64'(credit_overflow), 64'd0);
    chk("mrst_credit_out", 64'(credit_out), 64'd0);
    tick();
    tick();
    chk("mrst_pulses", 64'(credit_pulses), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
